lsu: RTL and testbench
======================

# lsu

Load/store unit between the MIPS core datapath and a multi-cycle data memory. Takes one access per instruction from the core: effective address, store data, size, and signedness. It checks alignment and builds word-aligned, byte-enabled memory transactions over a req/ack handshake. It stalls the core until the access completes and returns sign- or zero-extended load data.

## Interface
- ADDR_W, 32, byte address width.
- DATA_W, 32, data width. Fixed at 32; byte enables are DATA_W/8.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  core presents a memory instruction this cycle.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  in  1  loads only: 1 = zero-extend (lbu/lhu), 0 = sign-extend.
- req_addr  in  ADDR_W  effective byte address (ALU result).
- req_wdata  in  DATA_W  store data (rt), right-justified.
- stall  out  1  core must hold PC and instruction.
- rdata  out  DATA_W  extended load result, held until the next load completes.
- rdata_valid  out  1  one-cycle pulse when an access completes, load or store.
- misalign  out  1  access rejected: misaligned or illegal size.
- mem_req  out  1  transaction request, held until ack.
- mem_we  out  1  write transaction.
- mem_addr  out  ADDR_W  word-aligned address, req_addr with [1:0] = 00.
- mem_wdata  out  DATA_W  lane-replicated store data.
- mem_be  out  DATA_W/8  byte enables. Write only; 1111 on reads.
- mem_ack  in  1  memory completes the transaction.
- mem_rdata  in  DATA_W  read word, valid with mem_ack.

## Operation
- Byte order is little-endian: byte at addr[1:0] = n occupies bits 8n+7:8n.
- The FSM has three states: IDLE, WAIT, DONE.
- IDLE, with req_valid and a legal aligned request:
  - register mem_addr, mem_we, mem_be, mem_wdata, the lane offset, size and unsigned;
  - stall = 1;
  - go to WAIT.
- IDLE, with req_valid and a misaligned or illegal request:
  - misalign = 1 (combinational), stall = 0, no transaction, stay in IDLE.
  - Misaligned means half with addr[0] = 1, word with addr[1:0] ≠ 00, or size 11.
- WAIT:
  - mem_req = 1 and stall = 1; transaction fields stay stable.
  - On mem_ack: for loads, capture the extracted lane into rdata; go to DONE.
- DONE:
  - rdata_valid = 1, stall = 0, req_* ignored; go to IDLE.
  - The core advances on this edge, so the same instruction is never re-issued.
- Store lane rules:
  - byte: mem_wdata = {4{wdata[7:0]}}, mem_be = 0001 << off.
  - half: mem_wdata = {2{wdata[15:0]}}, mem_be = 0011 << off.
  - word: mem_wdata = wdata, mem_be = 1111.
- Load extract: select the byte or half at off, then sign- or zero-extend to 32 bits; word loads pass through.
- mem_ack outside WAIT is ignored.

## Timing
- Reset values: state IDLE; stall, rdata_valid, misalign, mem_req, mem_we = 0; rdata, mem_addr, mem_wdata = 0; mem_be = 0000.
- Reset asserted mid-transaction forces IDLE and mem_req = 0 immediately (asynchronous). Any pending ack is dropped.
- Latency: with the request accepted in cycle 0 and ack in cycle k ≥ 1, DONE is cycle k+1. stall is high in cycles 0..k.
  - Minimum is 3 cycles per access, with 2 stall cycles.
- mem_req first rises in cycle 1, registered. It is never asserted combinationally from req_valid.
- rdata updates on the ack edge and is stable from DONE onward. Stores do not modify rdata.
- misalign is valid in the same cycle as the request. It has no registered side effect.

## Structure
- The shared package mips_pkg holds:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD;
  - the lsu_state_t enum (IDLE, WAIT, DONE).
- One combinational sub-module, lsu_align, provides:
  - store side: mem_be and mem_wdata from size, offset and wdata;
  - load side: extended rdata from size, unsigned, offset and mem_rdata;
  - the misalign decode.
- lsu holds only the FSM and the registers.

## Test plan
- sw addr 0x10 data 0xDEADBEEF, ack 2 cycles after mem_req rises -> mem_addr 0x10, mem_be 1111, mem_wdata 0xDEADBEEF, mem_we 1; stall high 3 cycles; rdata_valid pulses once.
- lb addr 0x13, mem_rdata 0x80FF1234 -> rdata 0xFFFFFF80. lbu at the same address -> rdata 0x00000080.
- sh addr 0x22 data 0x0000ABCD -> mem_addr 0x20, mem_be 1100, mem_wdata 0xABCDABCD.
- lw addr 0x06, and separately size 11 at addr 0x00 -> misalign 1 in the same cycle, mem_req stays 0, stall 0.
- Reset low during WAIT -> mem_req and stall drop at once, rdata = 0. After release, lh addr 0x02 with mem_rdata 0x7FFF0000 -> rdata 0x00007FFF.
- Stray mem_ack pulses in IDLE and DONE -> no state change, no rdata update. Back-to-back loads each take ≥ 3 cycles.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS datapath: access sizes and LSU FSM states.
package mips_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering for the LSU: store byte enables and replicated
// write data, load lane extraction with sign/zero extension, and the
// misalignment decode for incoming requests.
module lsu_align
  import mips_pkg::*;
(
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_data,
  output logic [3:0]  st_be,
  output logic [31:0] st_wdata,
  output logic        bad,
  input  logic [1:0]  ld_size,
  input  logic        ld_unsigned,
  input  logic [1:0]  ld_off,
  input  logic [31:0] ld_word,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Store side: replicate data across lanes, enable only the addressed bytes.
  always_comb begin
    st_be    = '0;
    st_wdata = st_data;
    bad      = 1'b0;
    case (st_size)
      SZ_BYTE: begin
        st_be    = 4'b0001 << st_off;
        st_wdata = {4{st_data[7:0]}};
      end
      SZ_HALF: begin
        st_be    = 4'b0011 << st_off;
        st_wdata = {2{st_data[15:0]}};
        bad      = st_off[0];
      end
      SZ_WORD: begin
        st_be = 4'b1111;
        bad   = |st_off;
      end
      default: bad = 1'b1;
    endcase
  end

  // Load side: pick the addressed lane and extend it to a full word.
  always_comb begin
    ld_byte = ld_word[{ld_off, 3'b000} +: 8];
    ld_half = ld_word[{ld_off[1], 4'b0000} +: 16];
    case (ld_size)
      SZ_BYTE: ld_data = {{24{~ld_unsigned & ld_byte[7]}}, ld_byte};
      SZ_HALF: ld_data = {{16{~ld_unsigned & ld_half[15]}}, ld_half};
      default: ld_data = ld_word;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: accepts one access per instruction, runs a req/ack memory
// transaction, stalls the core until done and returns extended load data.
module lsu
  import mips_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                req_valid,
  input  logic                req_write,
  input  logic [1:0]          req_size,
  input  logic                req_unsigned,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                stall,
  output logic [DATA_W-1:0]   rdata,
  output logic                rdata_valid,
  output logic                misalign,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic                mem_ack,
  input  logic [DATA_W-1:0]   mem_rdata
);

  lsu_state_t  state, state_nxt;
  logic [1:0]  off_q, size_q;
  logic        uns_q;
  logic        accept;
  logic        bad_c;
  logic [3:0]  be_c;
  logic [31:0] wdata_c, ldata_c;

  lsu_align u_align (
    .st_size     (req_size),
    .st_off      (req_addr[1:0]),
    .st_data     (req_wdata),
    .st_be       (be_c),
    .st_wdata    (wdata_c),
    .bad         (bad_c),
    .ld_size     (size_q),
    .ld_unsigned (uns_q),
    .ld_off      (off_q),
    .ld_word     (mem_rdata),
    .ld_data     (ldata_c)
  );

  // Next-state and handshake outputs; mem_req derives from the state register only.
  always_comb begin
    state_nxt   = state;
    stall       = 1'b0;
    misalign    = 1'b0;
    mem_req     = 1'b0;
    rdata_valid = 1'b0;
    accept      = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (bad_c) begin
            misalign = 1'b1;
          end else begin
            accept    = 1'b1;
            stall     = 1'b1;
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        mem_req = 1'b1;
        stall   = 1'b1;
        if (mem_ack) state_nxt = DONE;
      end
      DONE: begin
        rdata_valid = 1'b1;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Transaction fields latched on accept; load result latched on the ack edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_be    <= '0;
      mem_wdata <= '0;
      off_q     <= '0;
      size_q    <= '0;
      uns_q     <= 1'b0;
      rdata     <= '0;
    end else begin
      if (accept) begin
        mem_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
        mem_we    <= req_write;
        mem_be    <= req_write ? be_c : '1;
        mem_wdata <= wdata_c;
        off_q     <= req_addr[1:0];
        size_q    <= req_size;
        uns_q     <= req_unsigned;
      end
      if (state == WAIT && mem_ack && !mem_we) rdata <= ldata_c;
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed vector table, multi-cycle corner
// sequences, and randomized accesses against a behavioural reference model.
module tb_lsu;
  import mips_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0, req_write = 1'b0, req_unsigned = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        stall, rdata_valid, misalign, mem_req, mem_we;
  logic [31:0] rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;

  int errors = 0;
  int checks = 0;
  logic [31:0] model_rdata = '0;

  lsu #(.ADDR_W(32), .DATA_W(32)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_write(req_write), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall), .rdata(rdata), .rdata_valid(rdata_valid), .misalign(misalign),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference model: rules expressed as plain arithmetic on byte counts.
  function automatic logic ref_bad(input logic [1:0] sz, input logic [31:0] addr);
    if (sz == 2'b11) return 1'b1;
    return (addr % (32'd1 << sz)) != 0;
  endfunction

  function automatic logic [3:0] ref_be(input logic wr, input logic [1:0] sz, input logic [31:0] addr);
    int unsigned nbytes, mask;
    if (!wr) return 4'hF;
    nbytes = 1 << sz;
    mask = ((1 << nbytes) - 1) << (addr % 4);
    return 4'(mask);
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [1:0] sz, input logic [31:0] wd);
    if (sz == 2'b00) return (wd & 32'hFF) * 32'h0101_0101;
    if (sz == 2'b01) return (wd & 32'hFFFF) * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic uns,
                                           input logic [31:0] addr, input logic [31:0] mrd);
    longint unsigned nbits, v;
    if (sz == 2'b10) return mrd;
    nbits = 64'd8 << sz;
    v = (64'(mrd) >> (8 * (addr % 4))) & ((64'd1 << nbits) - 1);
    if (!uns && v >= (64'd1 << (nbits - 1))) v = v + (64'h1_0000_0000 - (64'd1 << nbits));
    return 32'(v);
  endfunction

  // Runs one access starting at a negedge; returns at the negedge of the
  // cycle after completion (IDLE), so consecutive calls are back-to-back.
  task automatic access(input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] mrd,
                        input int k, input logic ack_in_done,
                        input logic exp_mis, input logic [31:0] exp_addr, input logic [3:0] exp_be,
                        input logic [31:0] exp_wd, input logic [31:0] exp_rd);
    int stalls;
    req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    #1;
    check("misalign", 32'(misalign), 32'(exp_mis));
    check("stall_c0", 32'(stall), 32'(!exp_mis));
    check("mem_req_c0", 32'(mem_req), 32'd0);
    if (exp_mis) begin
      @(negedge clock);
      req_valid = 1'b0;
      #1;
      check("mem_req_after_mis", 32'(mem_req), 32'd0);
      check("stall_after_mis", 32'(stall), 32'd0);
      check("rdata_after_mis", rdata, model_rdata);
      return;
    end
    stalls = 1;
    @(negedge clock);
    check("mem_addr", mem_addr, exp_addr);
    check("mem_we", 32'(mem_we), 32'(wr));
    check("mem_be", 32'(mem_be), 32'(exp_be));
    if (wr) check("mem_wdata", mem_wdata, exp_wd);
    for (int c = 1; c <= k; c++) begin
      check("mem_req_wait", 32'(mem_req), 32'd1);
      if (stall) stalls++;
      if (c == k) begin mem_ack = 1'b1; mem_rdata = mrd; end
      @(negedge clock);
      mem_ack = 1'b0;
      mem_rdata = $urandom;
    end
    if (!wr) model_rdata = exp_rd;
    check("stall_cycles", 32'(stalls), 32'(k + 1));
    check("rdata_valid_done", 32'(rdata_valid), 32'd1);
    check("stall_done", 32'(stall), 32'd0);
    check("mem_req_done", 32'(mem_req), 32'd0);
    check("rdata_done", rdata, model_rdata);
    req_valid = 1'b0;
    req_addr = $urandom;
    if (ack_in_done) begin mem_ack = 1'b1; mem_rdata = $urandom; end
    @(negedge clock);
    mem_ack = 1'b0;
    check("rdata_valid_idle", 32'(rdata_valid), 32'd0);
    check("mem_req_idle", 32'(mem_req), 32'd0);
    check("rdata_idle", rdata, model_rdata);
  endtask

  typedef struct {
    logic        wr;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] mrd;
    int          k;
    logic        ack_in_done;
    logic        exp_mis;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[$];

  initial begin
    vecs.push_back('{1'b1, SZ_WORD, 1'b0, 32'h10, 32'hDEAD_BEEF, 32'h0, 2, 1'b0, 1'b0, 32'h10, 4'hF, 32'hDEAD_BEEF, 32'h0});
    vecs.push_back('{1'b0, SZ_BYTE, 1'b0, 32'h13, 32'h0, 32'h80FF_1234, 1, 1'b1, 1'b0, 32'h10, 4'hF, 32'h0, 32'hFFFF_FF80});
    vecs.push_back('{1'b0, SZ_BYTE, 1'b1, 32'h13, 32'h0, 32'h80FF_1234, 3, 1'b0, 1'b0, 32'h10, 4'hF, 32'h0, 32'h0000_0080});
    vecs.push_back('{1'b1, SZ_HALF, 1'b0, 32'h22, 32'h0000_ABCD, 32'h0, 1, 1'b1, 1'b0, 32'h20, 4'hC, 32'hABCD_ABCD, 32'h0});
    vecs.push_back('{1'b0, SZ_WORD, 1'b0, 32'h06, 32'h0, 32'h0, 1, 1'b0, 1'b1, 32'h0, 4'h0, 32'h0, 32'h0});
    vecs.push_back('{1'b0, 2'b11,   1'b0, 32'h00, 32'h0, 32'h0, 1, 1'b0, 1'b1, 32'h0, 4'h0, 32'h0, 32'h0});
    vecs.push_back('{1'b0, SZ_HALF, 1'b0, 32'h46, 32'h0, 32'h8001_7FFF, 2, 1'b0, 1'b0, 32'h44, 4'hF, 32'h0, 32'hFFFF_8001});
    vecs.push_back('{1'b1, SZ_BYTE, 1'b0, 32'h31, 32'h1234_56A5, 32'h0, 1, 1'b0, 1'b0, 32'h30, 4'h2, 32'hA5A5_A5A5, 32'h0});

    // Reset state.
    #2;
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_rdata_valid", 32'(rdata_valid), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_mem_be", 32'(mem_be), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    // Directed table.
    foreach (vecs[i]) begin
      access(vecs[i].wr, vecs[i].sz, vecs[i].uns, vecs[i].addr, vecs[i].wd, vecs[i].mrd,
             vecs[i].k, vecs[i].ack_in_done, vecs[i].exp_mis, vecs[i].exp_addr, vecs[i].exp_be,
             vecs[i].exp_wd, vecs[i].wr ? model_rdata : vecs[i].exp_rd);
    end

    // Stray ack while IDLE must not start anything or touch rdata.
    @(negedge clock);
    mem_ack = 1'b1; mem_rdata = 32'h5555_AAAA;
    @(negedge clock);
    mem_ack = 1'b0;
    check("stray_idle_mem_req", 32'(mem_req), 32'd0);
    check("stray_idle_stall", 32'(stall), 32'd0);
    check("stray_idle_rvalid", 32'(rdata_valid), 32'd0);
    check("stray_idle_rdata", rdata, model_rdata);

    // Reset asserted during WAIT drops the transaction immediately.
    req_valid = 1'b1; req_write = 1'b0; req_size = SZ_WORD; req_unsigned = 1'b0; req_addr = 32'h80;
    @(negedge clock);
    req_valid = 1'b0;
    check("pre_reset_mem_req", 32'(mem_req), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("reset_mem_req", 32'(mem_req), 32'd0);
    check("reset_stall", 32'(stall), 32'd0);
    check("reset_rdata", rdata, 32'd0);
    model_rdata = '0;
    mem_ack = 1'b1;
    @(negedge clock);
    mem_ack = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    check("post_reset_mem_req", 32'(mem_req), 32'd0);
    check("post_reset_rdata", rdata, 32'd0);
    access(1'b0, SZ_HALF, 1'b0, 32'h02, 32'h0, 32'h7FFF_0000, 1, 1'b0,
           1'b0, 32'h00, 4'hF, 32'h0, 32'h0000_7FFF);

    // Randomized back-to-back accesses against the reference model.
    for (int n = 0; n < 60; n++) begin
      logic        wr, uns, bad;
      logic [1:0]  sz;
      logic [31:0] addr, wd, mrd;
      int          k;
      wr   = 1'($urandom);
      uns  = 1'($urandom);
      sz   = 2'($urandom_range(0, 3));
      addr = $urandom;
      wd   = $urandom;
      mrd  = $urandom;
      k    = $urandom_range(1, 4);
      bad  = ref_bad(sz, addr);
      access(wr, sz, uns, addr, wd, mrd, k, 1'($urandom), bad, addr & 32'hFFFF_FFFC,
             ref_be(wr, sz, addr), ref_wdata(sz, wd),
             wr ? model_rdata : ref_load(sz, uns, addr, mrd));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
